// File: rtl/stage_merge_1024_pkg.sv
// Shared FFT stage constants: default word geometry for the merge stage and
// the state encoding used by the merge controller.
package stage_merge_1024_pkg;

  // Width of one real or imaginary float part.
  localparam int MERGE_FLOAT_LEN = 32;

  // Number of butterfly pairs in one block; this is also the buffer depth.
  localparam int MERGE_DEPTH = 1024;

  // log2(MERGE_DEPTH), which is the buffer address width.
  localparam int MERGE_ADDR_LEN = 10;

  // Merge controller states. The encoding is kept as plain constants so that
  // older blocks comparing raw state bits keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PAIR  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // A complex word holds the real part and the imaginary part side by side.
  function automatic int merge_word_len(input int float_len);
    return 2 * float_len;
  endfunction

endpackage

// File: rtl/merge_bram.sv
// Simple dual-port buffer with one write port and one registered read port.
// The read register has no reset so that synthesis can map the array and the
// read register onto a block RAM.
module merge_bram #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 1024,
  parameter int ADDR_LEN = 10
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [ADDR_LEN-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic [ADDR_LEN-1:0] rd_addr_i,
  output logic [WIDTH-1:0]    rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port plus synchronous read. A read that hits the address being
  // written returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/stage_merge_1024.sv
// Merge stage: turns the two butterfly output streams into a single stream.
// While a block is being paired, each data_in1 value goes straight out and
// each data_in2 value is parked in the buffer. When the block is complete,
// the parked values are drained in order. Together this gives 2*DEPTH
// samples per block.
module stage_merge_1024
  import stage_merge_1024_pkg::*;
#(
  parameter int FLOAT_LEN = MERGE_FLOAT_LEN,
  parameter int DEPTH     = MERGE_DEPTH,
  parameter int ADDR_LEN  = MERGE_ADDR_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*FLOAT_LEN-1:0] data_in1,
  input  logic [2*FLOAT_LEN-1:0] data_in2,
  input  logic                   data_in_valid,
  output logic [2*FLOAT_LEN-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int WORD_W = merge_word_len(FLOAT_LEN);
  localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(DEPTH - 1);
  localparam logic [ADDR_LEN-1:0] ONE_IDX  = ADDR_LEN'(1);

  logic [1:0]          state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic                wr_en;
  logic [ADDR_LEN-1:0] wr_addr;
  logic [ADDR_LEN-1:0] rd_addr;
  logic [WORD_W-1:0]   rd_data;

  merge_bram #(
    .WIDTH    (WORD_W),
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (data_in2),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Next-state and datapath selection for the pair and drain phases.
  // Outside DRAIN the read port is held at address 0. As a result, buffer[0]
  // is already in the read register on the cycle the last pair is accepted.
  // During DRAIN, cnt_q is the index of the sample that goes out at the next
  // edge, and the read port fetches one entry ahead of it. That is why the
  // drain follows the last data_in1 output with no gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    rd_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (data_in_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          out_d   = data_in1;
          valid_d = 1'b1;
          cnt_d   = ONE_IDX;
          state_d = ST_PAIR;
        end
      end

      ST_PAIR: begin
        if (data_in_valid) begin
          wr_en   = 1'b1;
          out_d   = data_in1;
          valid_d = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + ONE_IDX;
          end
        end
      end

      ST_DRAIN: begin
        rd_addr = cnt_q + ONE_IDX;
        out_d   = rd_data;
        valid_d = 1'b1;
        if (data_in_valid) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == LAST_IDX) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_IDX;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers. Reset abandons any block in progress.
  // Buffer contents are left untouched because the next block overwrites
  // every entry before it is read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = valid_q;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_stage_merge_1024.sv
// Self-checking bench for stage_merge_1024. There are two instances: the
// default 1024-deep one and an 8-deep one.
module tb_stage_merge_1024;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic [63:0] in1, in2;
  logic        vIn;
  logic [63:0] data_out;
  logic        data_out_valid, frame_done, overflow;

  logic [63:0] a8, b8;
  logic        v8;
  logic [63:0] out8;
  logic        valid8, done8, ovf8;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] d;
    int          c;
    bit          done;
  } rec_t;

  rec_t outLog[$];
  rec_t log8[$];

  stage_merge_1024 dut (
    .clk            (clk),
    .rst            (rst),
    .data_in1       (in1),
    .data_in2       (in2),
    .data_in_valid  (vIn),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_done     (frame_done),
    .overflow       (overflow)
  );

  stage_merge_1024 #(.FLOAT_LEN(32), .DEPTH(8), .ADDR_LEN(3)) dut8 (
    .clk            (clk),
    .rst            (rst),
    .data_in1       (a8),
    .data_in2       (b8),
    .data_in_valid  (v8),
    .data_out       (out8),
    .data_out_valid (valid8),
    .frame_done     (done8),
    .overflow       (ovf8)
  );

  // Clock generation and the cycle stamp.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passes++;
    end
  endtask

  // Reference model: gather the in2 values of a block, then replay them.
  // Each edge produces the output that must be visible after that edge.
  logic [63:0] mBuf[$];
  int          mDrainIdx;
  bit          mDraining;
  logic [63:0] expData;
  logic        expValid, expDone, expOvf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBuf.delete();
      mDraining = 1'b0;
      mDrainIdx = 0;
      expData   = '0;
      expValid  = 1'b0;
      expDone   = 1'b0;
      expOvf    = 1'b0;
    end else begin
      expValid = 1'b0;
      expDone  = 1'b0;
      if (mDraining) begin
        if (vIn) expOvf = 1'b1;
        expData  = mBuf[mDrainIdx];
        expValid = 1'b1;
        mDrainIdx++;
        if (mDrainIdx == DEPTH) begin
          expDone   = 1'b1;
          mDraining = 1'b0;
          mDrainIdx = 0;
          mBuf.delete();
        end
      end else if (vIn) begin
        expData  = in1;
        expValid = 1'b1;
        mBuf.push_back(in2);
        if (mBuf.size() == DEPTH) mDraining = 1'b1;
      end
    end
  end

  // Per-cycle compare of the full output tuple against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("stream", {61'd0, data_out_valid, frame_done, overflow, data_out},
                  {61'd0, expValid, expDone, expOvf, expData});
    end
  end

  // Output logs, used by the literal checks that pin the model.
  always @(negedge clk) begin
    if (!rst && data_out_valid) outLog.push_back('{d: data_out, c: cyc, done: frame_done});
    if (!rst && valid8) log8.push_back('{d: out8, c: cyc, done: done8});
  end

  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    vIn = v;
    in1 = a;
    in2 = b;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, '0, '0);
      n++;
    end while (!frame_done && n < budget);
    checkOutput("frame_done_wait", {127'd0, frame_done}, 128'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #10 rst = 1'b0;
  endtask

  initial begin
    int firstPairCyc;
    rst = 1'b0;
    vIn = 1'b0; in1 = '0; in2 = '0;
    v8 = 1'b0; a8 = '0; b8 = '0;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_data", {64'd0, data_out}, 128'd0);
    checkOutput("reset_valid", {127'd0, data_out_valid}, 128'd0);
    checkOutput("reset_done", {127'd0, frame_done}, 128'd0);
    checkOutput("reset_ovf", {127'd0, overflow}, 128'd0);
    #19 rst = 1'b0;

    // Contiguous block.
    outLog.delete();
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 64'(k), 64'(32'h1000 + k));
      if (k == 0) firstPairCyc = cyc;
    end
    idleCycles(1100);
    checkOutput("blk1_count", 128'(outLog.size()), 128'd2048);
    checkOutput("blk1_latency", 128'(outLog[0].c - firstPairCyc), 128'd1);
    checkOutput("blk1_first", {64'd0, outLog[0].d}, 128'h0);
    checkOutput("blk1_in1_last", {64'd0, outLog[1023].d}, 128'h3FF);
    checkOutput("blk1_drain_first", {64'd0, outLog[1024].d}, 128'h1000);
    checkOutput("blk1_drain_last", {64'd0, outLog[2047].d}, 128'h13FF);
    checkOutput("blk1_contiguous", 128'(outLog[2047].c - outLog[0].c), 128'd2047);
    checkOutput("blk1_done_last", {127'd0, outLog[2047].done}, 128'd1);
    checkOutput("blk1_done_early", {127'd0, outLog[2046].done}, 128'd0);

    // Valid toggling 1,0 while pairing.
    outLog.delete();
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 64'(k), 64'(32'h2000 + k));
      if (k != DEPTH - 1) applyStimulus(1'b0, '0, '0);
    end
    idleCycles(1100);
    checkOutput("gap_count", 128'(outLog.size()), 128'd2048);
    checkOutput("gap_spacing", 128'(outLog[1].c - outLog[0].c), 128'd2);
    checkOutput("gap_in1_span", 128'(outLog[1023].c - outLog[0].c), 128'd2046);
    checkOutput("gap_drain_start", 128'(outLog[1024].c - outLog[1023].c), 128'd1);
    checkOutput("gap_drain_span", 128'(outLog[2047].c - outLog[1024].c), 128'd1023);
    checkOutput("gap_drain_first", {64'd0, outLog[1024].d}, 128'h2000);

    // Pair burst during drain -> sticky overflow.
    outLog.delete();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 64'(32'h3000 + k), 64'(32'h4000 + k));
    idleCycles(9);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 64'(32'h9000 + k), 64'(32'h9900 + k));
    applyStimulus(1'b0, '0, '0);
    checkOutput("ovf_set", {127'd0, overflow}, 128'd1);
    idleCycles(1100);
    checkOutput("ovf_count", 128'(outLog.size()), 128'd2048);
    checkOutput("ovf_drain_0", {64'd0, outLog[1024].d}, 128'h4000);
    checkOutput("ovf_drain_10", {64'd0, outLog[1034].d}, 128'h400A);
    checkOutput("ovf_drain_last", {64'd0, outLog[2047].d}, 128'h43FF);
    checkOutput("ovf_held", {127'd0, overflow}, 128'd1);
    doReset();
    checkOutput("ovf_cleared", {127'd0, overflow}, 128'd0);

    // Back-to-back blocks.
    outLog.delete();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 64'(32'h5000 + k), 64'(32'h6000 + k));
    waitDone(1100);
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 64'(32'h7000 + k), 64'(32'h8000 + k));
    idleCycles(1100);
    checkOutput("b2b_count", 128'(outLog.size()), 128'd4096);
    checkOutput("b2b_second_first", {64'd0, outLog[2048].d}, 128'h7000);
    checkOutput("b2b_second_gap", 128'(outLog[2048].c - outLog[2047].c), 128'd2);
    checkOutput("b2b_last", {64'd0, outLog[4095].d}, 128'h83FF);
    checkOutput("b2b_no_ovf", {127'd0, overflow}, 128'd0);

    // Asynchronous reset in the middle of pairing.
    for (int k = 0; k < 500; k++) applyStimulus(1'b1, 64'(32'hA000 + k), 64'(32'hB000 + k));
    applyStimulus(1'b1, 64'(32'hA000 + 500), 64'(32'hB000 + 500));
    #2 rst = 1'b1;
    vIn = 1'b0;
    #1;
    checkOutput("async_rst_data", {64'd0, data_out}, 128'd0);
    checkOutput("async_rst_valid", {127'd0, data_out_valid}, 128'd0);
    #9 rst = 1'b0;
    outLog.delete();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 64'(32'hC000 + k), 64'(32'hD000 + k));
    idleCycles(1100);
    checkOutput("rst_blk_count", 128'(outLog.size()), 128'd2048);
    checkOutput("rst_blk_first", {64'd0, outLog[0].d}, 128'hC000);
    checkOutput("rst_blk_drain_first", {64'd0, outLog[1024].d}, 128'hD000);
    checkOutput("rst_blk_drain_500", {64'd0, outLog[1524].d}, 128'hD1F4);
    checkOutput("rst_blk_drain_last", {64'd0, outLog[2047].d}, 128'hD3FF);

    // Eight-deep instance: two blocks, so the index wraps twice.
    log8.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 8) begin
        v8 = 1'b1; a8 = 64'(32'h10 + i); b8 = 64'(32'h20 + i);
      end else if (i >= 20 && i < 28) begin
        v8 = 1'b1; a8 = 64'(32'h30 + i - 20); b8 = 64'(32'h40 + i - 20);
      end else begin
        v8 = 1'b0; a8 = '0; b8 = '0;
      end
    end
    idleCycles(4);
    checkOutput("d8_count", 128'(log8.size()), 128'd32);
    if (log8.size() == 32) begin
      for (int j = 0; j < 32; j++) begin
        int idx;
        int base;
        idx  = j % 16;
        base = (j < 16) ? 32'h10 : 32'h30;
        checkOutput($sformatf("d8_data_%0d", j), {64'd0, log8[j].d},
                    128'((idx < 8) ? base + idx : base + 32'h10 + idx - 8));
        checkOutput($sformatf("d8_done_%0d", j), {127'd0, log8[j].done}, 128'(idx == 15));
      end
      checkOutput("d8_contiguous", 128'(log8[15].c - log8[0].c), 128'd15);
    end
    checkOutput("d8_no_ovf", {127'd0, ovf8}, 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/stage_merge_1024.md
STAGE_MERGE_1024 -- requirements
Module: stage_merge_1024

Interface
REQ-001 SHALL have parameter FLOAT_LEN, default 32, meaning float width of one real/imag part; complex word = 2*FLOAT_LEN bits.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning pairs per block and buffer depth.
REQ-003 SHALL have parameter ADDR_LEN, default 10, meaning log2(DEPTH).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data_in1  input  2*FLOAT_LEN  upper butterfly output (x1 path), {real, imag}.
REQ-007 SHALL have port data_in2  input  2*FLOAT_LEN  lower butterfly output (x2 path), {real, imag}.
REQ-008 SHALL have port data_in_valid  input  1  data_in1/data_in2 pair valid this cycle.
REQ-009 SHALL have port data_out  output  2*FLOAT_LEN  serialized single-stream sample.
REQ-010 SHALL have port data_out_valid  output  1  data_out valid this cycle.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse with last drained sample.
REQ-012 SHALL have port overflow  output  1  sticky; pair arrived while draining.

Function
REQ-013 SHALL implement states IDLE, PAIR, DRAIN; reset state IDLE.
REQ-014 IDLE: data_in_valid=1 -> write pair index 0, go to PAIR with pair count 1.
REQ-015 PAIR: each valid pair k SHALL put data_in1 on data_out one cycle later, data_out_valid=1, and write data_in2 to buffer address k.
REQ-016 PAIR: data_in_valid=0 SHALL stall (count held, data_out_valid=0 next cycle, no write).
REQ-017 When pair DEPTH-1 is accepted, SHALL enter DRAIN; count wraps to 0.
REQ-018 DRAIN: SHALL output buffer[0..DEPTH-1] in order on consecutive cycles, buffer[0] on the cycle after the last data_in1 output, so a block yields 2*DEPTH contiguous valid outputs.
REQ-019 frame_done SHALL be 1 exactly on the cycle buffer[DEPTH-1] is output; then go to IDLE.
REQ-020 DRAIN: data_in_valid=1 SHALL set overflow, pair dropped, drain unaffected.
REQ-021 Block arriving in the cycle after frame_done SHALL be accepted normally (IDLE accept).
REQ-022 Data SHALL pass bit-exact; no arithmetic or rounding.
REQ-023 data_out SHALL be registered; holds last value when data_out_valid=0.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, counters 0, data_out 0, data_out_valid 0, frame_done 0, overflow 0.
REQ-025 Reset mid-PAIR or mid-DRAIN SHALL abandon the block; buffer contents need not be cleared; next valid after release starts new block at index 0.
REQ-026 overflow SHALL clear only on rst.

Structure
REQ-027 FLOAT_LEN, DEPTH, ADDR_LEN defaults and state encoding SHALL live in the shared FFT package alongside other stage constants.
REQ-028 Buffer SHALL be a sub-module merge_bram: simple dual-port, 1 write/1 synchronous read port, DEPTH x 2*FLOAT_LEN, BRAM-inferable.
REQ-029 Control (FSM, address counters) SHALL stay in stage_merge_1024.

Verification
REQ-030 1024 contiguous pairs in1=k, in2=0x1000+k -> 2048 contiguous outputs 0..1023 then 0x1000..0x13FF, first output 1 cycle after first pair, frame_done on output 2048.
REQ-031 Pairs with valid toggling 1,0 -> outputs in1 values with gaps, count reaches 1024 after 2047 input cycles, drain still contiguous 1024 cycles.
REQ-032 Second pair burst driven at drain cycle 10 -> overflow=1 from next cycle, drain order unchanged, overflow held until rst.
REQ-033 Two back-to-back blocks (second starts cycle after frame_done) -> 4096 correct outputs, no overflow.
REQ-034 rst asserted at pair 500 for 1 cycle, async mid-cycle -> outputs/valid 0 immediately; next block of 1024 drains buffer[0..1023] from new block only.
REQ-035 DEPTH=8, ADDR_LEN=3 -> 16 outputs, wrap 7->0 correct, frame_done on output 16.
